// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman modular exponentiation slice.
package dh_pkg;

    localparam int unsigned DH_W     = 32;
    localparam int unsigned DH_EXP_W = 32;
    localparam int unsigned DH_ACC_W = DH_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_RED,
        S_MUL,
        S_SQR,
        S_NEXT,
        S_FIN
    } state_e;

endpackage

// File: rtl/mod_mul_seq.sv
// Interleaved shift-subtract (Blakley) modular multiplier: y = a*b mod p, b < p.
// done pulses exactly W cycles after start; the first iteration runs on the start edge.
module mod_mul_seq
    import dh_pkg::*;
#(
    parameter int unsigned W = DH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         done,
    output logic [W-1:0] y
);

    localparam int unsigned ACC_W = W + 2;
    localparam int unsigned CW    = $clog2(W + 1);

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // acc < p and b < p keep t below 3p, so two conditional subtracts suffice.
    function automatic logic [W-1:0] blakley_step(input logic [W-1:0] acc,
                                                  input logic         a_bit,
                                                  input logic [W-1:0] bv,
                                                  input logic [W-1:0] pv);
        logic [ACC_W-1:0] t;
        logic [ACC_W-1:0] pe;
        pe = {2'b00, pv};
        t  = {1'b0, acc, 1'b0} + (a_bit ? {2'b00, bv} : '0);
        if (t >= pe) t = t - pe;
        if (t >= pe) t = t - pe;
        return t[W-1:0];
    endfunction

    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            acc_d  = blakley_step('0, a[W-1], b, p);
            a_d    = a << 1;
            b_d    = b;
            p_d    = p;
            cnt_d  = CW'(W - 1);
            busy_d = (W > 1);
            done_d = (W == 1);
        end else if (busy_q) begin
            acc_d = blakley_step(acc_q, a_q[W-1], b_q, p_q);
            a_d   = a_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign y    = acc_q;

endmodule

// File: rtl/mod_exp_seq.sv
// Right-to-left square-and-multiply modular exponentiation r = base^exp mod p,
// time-sharing one sequential Blakley multiplier across RED/MUL/SQR.
module mod_exp_seq
    import dh_pkg::*;
#(
    parameter int unsigned W     = DH_W,
    parameter int unsigned EXP_W = DH_EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic [W-1:0]     base,
    input  logic [EXP_W-1:0] exp,
    input  logic [W-1:0]     p,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     r,
    output logic             err
);

    localparam int unsigned    IW       = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(EXP_W - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     base_q, base_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [W-1:0]     p_q, p_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     r_q, r_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             issued_q, issued_d;
    logic             err_q, err_d;
    logic [IW-1:0]    idx_nxt;

    logic             mul_start;
    logic             mul_done;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [W-1:0]     mul_y;

    mod_mul_seq #(.W(W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .p     (p_q),
        .done  (mul_done),
        .y     (mul_y)
    );

    function automatic state_e bit_state(input logic bit_set, input logic last);
        return bit_set ? S_MUL : (last ? S_FIN : S_SQR);
    endfunction

    always_comb idx_nxt = idx_q + IW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // The NEXT bookkeeping step is folded into the cycle where SQR completes,
    // so every multiply costs exactly W+1 cycles with no extra gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (st) state_d = S_CHK;
            S_CHK:  state_d = (p_q <= W'(1)) ? S_FIN : S_RED;
            S_RED:  if (mul_done) state_d = bit_state(exp_q[0], EXP_W == 1);
            S_MUL:  if (mul_done) state_d = (idx_q == LAST_IDX) ? S_FIN : S_SQR;
            S_SQR:  if (mul_done) state_d = bit_state(exp_q[idx_nxt], idx_nxt == LAST_IDX);
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
        r         = r_q;
        err       = err_q;
        mul_start = 1'b0;
        mul_a     = base_q;
        mul_b     = W'(1);
        case (state_q)
            S_RED: mul_start = !issued_q;
            S_MUL: begin
                mul_start = !issued_q;
                mul_a     = acc_q;
                mul_b     = b_q;
            end
            S_SQR: begin
                mul_start = !issued_q;
                mul_a     = b_q;
                mul_b     = b_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        base_d   = base_q;
        exp_d    = exp_q;
        p_d      = p_q;
        b_d      = b_q;
        acc_d    = acc_q;
        r_d      = r_q;
        idx_d    = idx_q;
        issued_d = issued_q;
        err_d    = err_q;
        if (state_q == S_IDLE) begin
            if (st) begin
                base_d = base;
                exp_d  = exp;
                p_d    = p;
                err_d  = 1'b0;
            end
        end else if (state_q == S_CHK) begin
            err_d    = (p_q == '0);
            acc_d    = W'(1);
            idx_d    = '0;
            issued_d = 1'b0;
            if (p_q <= W'(1)) r_d = '0;
        end else if (state_q == S_RED || state_q == S_MUL || state_q == S_SQR) begin
            if (mul_start) issued_d = 1'b1;
            if (mul_done) begin
                issued_d = 1'b0;
                if (state_q == S_MUL) begin
                    acc_d = mul_y;
                end else begin
                    b_d = mul_y;
                end
                if (state_q == S_SQR) idx_d = idx_nxt;
                if (state_d == S_FIN) r_d = (state_q == S_MUL) ? mul_y : acc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q   <= '0;
            exp_q    <= '0;
            p_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            issued_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            exp_q    <= exp_d;
            p_q      <= p_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            r_q      <= r_d;
            idx_q    <= idx_d;
            issued_q <= issued_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mod_exp_seq.sv
// Randomised self-checking bench for mod_exp_seq against a plain-arithmetic
// square-and-multiply model and the closed-form latency.
module tb_mod_exp_seq;

    localparam int MAX32 = 4000;
    localparam int MAX8  = 400;

    logic        clk = 1'b0;
    logic        rst;

    logic        st32;
    logic [31:0] base32, exp32, p32, r32;
    logic        busy32, done32, err32;

    logic        st8;
    logic [7:0]  base8, exp8, p8, r8;
    logic        busy8, done8, err8;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mod_exp_seq #(.W(32), .EXP_W(32)) dut32 (
        .clk(clk), .rst(rst), .st(st32), .base(base32), .exp(exp32), .p(p32),
        .busy(busy32), .done(done32), .r(r32), .err(err32)
    );

    mod_exp_seq #(.W(8), .EXP_W(8)) dut8 (
        .clk(clk), .rst(rst), .st(st8), .base(base8), .exp(exp8), .p(p8),
        .busy(busy8), .done(done8), .r(r8), .err(err8)
    );

    function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [63:0] e,
                                            input logic [63:0] m, input int ew);
        logic [63:0] acc, x;
        if (m <= 1) return 64'd0;
        acc = 1;
        x   = b % m;
        for (int i = 0; i < ew; i++) begin
            if (e[i]) acc = (acc * x) % m;
            x = (x * x) % m;
        end
        return acc;
    endfunction

    function automatic int ref_lat(input logic [63:0] e, input logic [63:0] m,
                                   input int w, input int ew);
        if (m <= 1) return 2;
        return 2 + (w + 1) * (ew + $countones(e));
    endfunction

    task automatic run32(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                         output logic [31:0] rr, output logic ee, output int lat,
                         output logic busy_ok);
        @(negedge clk);
        base32 = b; exp32 = e; p32 = m; st32 = 1'b1;
        lat = 0; rr = '0; ee = 1'b0; busy_ok = 1'b1;
        for (int c = 1; c <= MAX32; c++) begin
            @(negedge clk);
            st32 = 1'b0;
            base32 = $urandom; exp32 = $urandom; p32 = $urandom;
            if (busy32 !== 1'b1) busy_ok = 1'b0;
            if (done32 === 1'b1) begin
                lat = c; rr = r32; ee = err32;
                break;
            end
        end
    endtask

    task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        output logic [7:0] rr, output logic ee, output int lat);
        @(negedge clk);
        base8 = b; exp8 = e; p8 = m; st8 = 1'b1;
        lat = 0; rr = '0; ee = 1'b0;
        for (int c = 1; c <= MAX8; c++) begin
            @(negedge clk);
            st8 = 1'b0;
            base8 = 8'($urandom); exp8 = 8'($urandom); p8 = 8'($urandom);
            if (done8 === 1'b1) begin
                lat = c; rr = r8; ee = err8;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy32); end
        vectors++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done32); end
        vectors++; if (r32 !== 32'd0) begin errors++; $display("FAIL reset_r: got %h want 0", r32); end
        vectors++; if (err32 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err32); end
        vectors++; if (busy8 !== 1'b0 || r8 !== 8'd0) begin errors++; $display("FAIL reset_dut8: busy %b r %h want 0 0", busy8, r8); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] tb_b[3] = '{32'd5, 32'd100, 32'd9};
        logic [31:0] tb_e[3] = '{32'd3, 32'd1, 32'd0};
        logic [31:0] tb_m[3] = '{32'd17, 32'd7, 32'd17};
        logic [31:0] tb_r[3] = '{32'd6, 32'd2, 32'd1};
        int          tb_l[3] = '{1124, 1091, 1058};
        logic [31:0] rr; logic ee; int lat; logic bok;
        for (int i = 0; i < 3; i++) begin
            run32(tb_b[i], tb_e[i], tb_m[i], rr, ee, lat, bok);
            vectors++; if (lat !== tb_l[i]) begin errors++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, tb_l[i]); end
            vectors++; if (rr !== tb_r[i]) begin errors++; $display("FAIL basic_r[%0d]: got %0d want %0d", i, rr, tb_r[i]); end
            vectors++; if (ee !== 1'b0) begin errors++; $display("FAIL basic_err[%0d]: got %b want 0", i, ee); end
            vectors++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: busy dropped during op", i); end
        end
        @(negedge clk);
        vectors++; if (done32 !== 1'b0 || busy32 !== 1'b0) begin errors++; $display("FAIL after_done: done %b busy %b want 0 0", done32, busy32); end
    endtask

    task automatic test_p_le_1();
        logic [31:0] rr; logic ee; int lat; logic bok;
        run32(32'd5, 32'd3, 32'd0, rr, ee, lat, bok);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL p0_lat: got %0d want 2", lat); end
        vectors++; if (ee !== 1'b1) begin errors++; $display("FAIL p0_err: got %b want 1", ee); end
        vectors++; if (rr !== 32'd0) begin errors++; $display("FAIL p0_r: got %h want 0", rr); end
        run32(32'd5, 32'd3, 32'd1, rr, ee, lat, bok);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL p1_lat: got %0d want 2", lat); end
        vectors++; if (ee !== 1'b0) begin errors++; $display("FAIL p1_err: got %b want 0", ee); end
        vectors++; if (rr !== 32'd0) begin errors++; $display("FAIL p1_r: got %h want 0", rr); end
        run32(32'd7, 32'd9, 32'd0, rr, ee, lat, bok);
        vectors++; if (ee !== 1'b1) begin errors++; $display("FAIL p0b_err: got %b want 1", ee); end
        run32(32'd3, 32'd5, 32'd17, rr, ee, lat, bok);
        vectors++; if (ee !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", ee); end
        vectors++; if (rr !== 32'd5) begin errors++; $display("FAIL err_clear_r: got %0d want 5", rr); end
        vectors++; if (lat !== 1124) begin errors++; $display("FAIL err_clear_lat: got %0d want 1124", lat); end
    endtask

    task automatic test_fermat();
        logic [31:0] rr; logic ee; int lat; logic bok;
        run32(32'd2, 32'd4294967290, 32'd4294967291, rr, ee, lat, bok);
        vectors++; if (rr !== 32'd1) begin errors++; $display("FAIL fermat_r: got %0d want 1", rr); end
        vectors++; if (lat !== 2048) begin errors++; $display("FAIL fermat_lat: got %0d want 2048", lat); end
        run32(32'd3, 32'd5, 32'd4294967291, rr, ee, lat, bok);
        vectors++; if (rr !== 32'd243) begin errors++; $display("FAIL pow35_r: got %0d want 243", rr); end
    endtask

    task automatic test_random32();
        logic [31:0] b, e, m, rr; logic ee; int lat; logic bok;
        for (int i = 0; i < 10; i++) begin
            b = $urandom; e = $urandom;
            m = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run32(b, e, m, rr, ee, lat, bok);
            vectors++; if (rr !== 32'(ref_pow(64'(b), 64'(e), 64'(m), 32))) begin
                errors++; $display("FAIL rand32_r: %h^%h mod %h got %h want %h", b, e, m, rr, 32'(ref_pow(64'(b), 64'(e), 64'(m), 32)));
            end
            vectors++; if (ee !== (m == 0)) begin errors++; $display("FAIL rand32_err: p %h got %b", m, ee); end
            vectors++; if (lat !== ref_lat(64'(e), 64'(m), 32, 32)) begin
                errors++; $display("FAIL rand32_lat: got %0d want %0d", lat, ref_lat(64'(e), 64'(m), 32, 32));
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0] b, e, m, rr; logic ee; int lat;
        for (int i = 0; i < 150; i++) begin
            b = 8'($urandom); e = 8'($urandom);
            m = (i % 10 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            run8(b, e, m, rr, ee, lat);
            vectors++; if (rr !== 8'(ref_pow(64'(b), 64'(e), 64'(m), 8))) begin
                errors++; $display("FAIL rand8_r: %0d^%0d mod %0d got %0d want %0d", b, e, m, rr, 8'(ref_pow(64'(b), 64'(e), 64'(m), 8)));
            end
            vectors++; if (ee !== (m == 0)) begin errors++; $display("FAIL rand8_err: p %0d got %b", m, ee); end
            vectors++; if (lat !== ref_lat(64'(e), 64'(m), 8, 8)) begin
                errors++; $display("FAIL rand8_lat: got %0d want %0d", lat, ref_lat(64'(e), 64'(m), 8, 8));
            end
        end
    endtask

    task automatic test_hold_st();
        logic [7:0] b1, e1, m1, b2, e2, m2, rr;
        int lat;
        b1 = 8'd7; e1 = 8'd10; m1 = 8'd13;
        @(negedge clk);
        base8 = b1; exp8 = e1; p8 = m1; st8 = 1'b1;
        lat = 0; rr = '0;
        for (int c = 1; c <= MAX8; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin lat = c; rr = r8; break; end
            base8 = 8'($urandom); exp8 = 8'($urandom); p8 = 8'($urandom);
        end
        vectors++; if (rr !== 8'(ref_pow(64'(b1), 64'(e1), 64'(m1), 8))) begin
            errors++; $display("FAIL hold_r: got %0d want %0d", rr, 8'(ref_pow(64'(b1), 64'(e1), 64'(m1), 8)));
        end
        vectors++; if (lat !== ref_lat(64'(e1), 64'(m1), 8, 8)) begin
            errors++; $display("FAIL hold_lat: got %0d want %0d", lat, ref_lat(64'(e1), 64'(m1), 8, 8));
        end
        // st stays high through the done cycle; the idle cycle after it accepts.
        @(negedge clk);
        vectors++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL hold_idle: busy %b done %b want 0 0", busy8, done8); end
        b2 = 8'($urandom); e2 = 8'($urandom); m2 = 8'($urandom_range(2, 255));
        base8 = b2; exp8 = e2; p8 = m2;
        @(negedge clk);
        st8 = 1'b0;
        vectors++; if (busy8 !== 1'b1) begin errors++; $display("FAIL hold_reaccept: busy %b want 1", busy8); end
        lat = 0;
        for (int c = 2; c <= MAX8; c++) begin
            @(negedge clk);
            base8 = 8'($urandom); exp8 = 8'($urandom); p8 = 8'($urandom);
            if (done8 === 1'b1) begin lat = c; rr = r8; break; end
        end
        vectors++; if (rr !== 8'(ref_pow(64'(b2), 64'(e2), 64'(m2), 8))) begin
            errors++; $display("FAIL hold2_r: got %0d want %0d", rr, 8'(ref_pow(64'(b2), 64'(e2), 64'(m2), 8)));
        end
        vectors++; if (lat !== ref_lat(64'(e2), 64'(m2), 8, 8)) begin
            errors++; $display("FAIL hold2_lat: got %0d want %0d", lat, ref_lat(64'(e2), 64'(m2), 8, 8));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rr; logic ee; int lat; logic bok;
        run32(32'd7, 32'd2, 32'd11, rr, ee, lat, bok);
        vectors++; if (rr !== 32'd5) begin errors++; $display("FAIL pre_reset_r: got %0d want 5", rr); end
        @(negedge clk);
        base32 = 32'd5; exp32 = 32'd3; p32 = 32'd17; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        repeat (499) @(negedge clk);
        vectors++; if (busy32 !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy32); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (busy32 !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy32); end
        vectors++; if (done32 !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done32); end
        vectors++; if (r32 !== 32'd0) begin errors++; $display("FAIL arst_r: got %h want 0", r32); end
        vectors++; if (err32 !== 1'b0) begin errors++; $display("FAIL arst_err: got %b want 0", err32); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run32(32'd5, 32'd3, 32'd17, rr, ee, lat, bok);
        vectors++; if (rr !== 32'd6) begin errors++; $display("FAIL post_reset_r: got %0d want 6", rr); end
        vectors++; if (lat !== 1124) begin errors++; $display("FAIL post_reset_lat: got %0d want 1124", lat); end
    endtask

    initial begin
        st32 = 1'b0; base32 = '0; exp32 = '0; p32 = '0;
        st8  = 1'b0; base8  = '0; exp8  = '0; p8  = '0;
        test_reset();
        test_basic();
        test_p_le_1();
        test_fermat();
        test_random32();
        test_random8();
        test_hold_st();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
